// File: rtl/debounce_bank.sv
// Per-channel synchronise-and-debounce bank with optional registered edge pulses.
// Define DEBOUNCE_BANK_EDGE_EN to build the oRise/oFall registers; otherwise they are tied to 0.
module debounce_bank #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic                iTick,
    input  logic [CHANNELS-1:0] iD,
    output logic [CHANNELS-1:0] oQ,
    output logic [CHANNELS-1:0] oRise,
    output logic [CHANNELS-1:0] oFall
);

    localparam int              CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] samp;
    logic [CHANNELS-1:0] load;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   q_r;
        logic                   mismatch;

        // Synchroniser runs every clock; iTick only gates the stability counter.
        always_ff @(posedge iClk or negedge iRst_n) begin
            if (!iRst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], iD[ch]};
            end
        end

        assign samp[ch]  = sync_q[SYNC_STAGES-1];
        assign mismatch  = samp[ch] ^ q_r;
        assign load[ch]  = mismatch & iTick & (cnt_q == CNT_TC);

        // Saturates at the terminal count, where the new level is accepted and the count restarts.
        always_ff @(posedge iClk or negedge iRst_n) begin
            if (!iRst_n) begin
                cnt_q <= '0;
            end else if (!mismatch) begin
                cnt_q <= '0;
            end else if (iTick) begin
                if (cnt_q == CNT_TC) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge iClk or negedge iRst_n) begin
            if (!iRst_n) begin
                q_r <= 1'b0;
            end else if (load[ch]) begin
                q_r <= samp[ch];
            end
        end

        assign oQ[ch] = q_r;
    end

`ifdef DEBOUNCE_BANK_EDGE_EN
    logic [CHANNELS-1:0] rise_r;
    logic [CHANNELS-1:0] fall_r;

    // load implies samp differs from oQ, so rise and fall are mutually exclusive.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rise_r <= '0;
            fall_r <= '0;
        end else begin
            rise_r <= load & samp;
            fall_r <= load & ~samp;
        end
    end

    assign oRise = rise_r;
    assign oFall = fall_r;
`else
    assign oRise = '0;
    assign oFall = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: vector table with event scoreboard plus reset and
// single-cycle-stability corner sequences.
module tb_debounce_bank;

    localparam int CH     = 4;
    localparam int STABLE = 16;
    localparam int SYNC   = 2;
`ifdef DEBOUNCE_BANK_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic          iClk   = 1'b0;
    logic          iRst_n = 1'b0;
    logic          iTick  = 1'b1;
    logic [CH-1:0] iD     = '0;
    logic [CH-1:0] oQ, oRise, oFall;

    logic [0:0] d1 = '0;
    logic [0:0] q1, r1, f1;

    debounce_bank #(.CHANNELS(CH), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iTick(iTick), .iD(iD),
        .oQ(oQ), .oRise(oRise), .oFall(oFall)
    );

    // Minimum stability window with a deeper synchroniser.
    debounce_bank #(.CHANNELS(1), .STABLE_CYCLES(1), .SYNC_STAGES(3)) dut1 (
        .iClk(iClk), .iRst_n(iRst_n), .iTick(iTick), .iD(d1),
        .oQ(q1), .oRise(r1), .oFall(f1)
    );

    always #5 iClk = ~iClk;

    int cyc      = 0;
    int tick_div = 1;
    int checks   = 0;
    int errors   = 0;

    always @(posedge iClk) cyc <= cyc + 1;

    // Tick for edge e is set up at the negedge where cyc == e-1.
    always @(negedge iClk) iTick = (tick_div <= 1) || ((cyc % tick_div) == 0);

    typedef struct {
        int            cyc;
        logic [CH-1:0] q;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
    } ev_t;

    typedef struct {
        logic [CH-1:0] d;
        int            div;
        int            hold;
        logic [CH-1:0] exp_q;
    } vec_t;

    ev_t           exp_q[$];
    logic [CH-1:0] prev_q = '0;
    bit            mon_en = 1'b0;

    always @(negedge iClk) begin
        ev_t e;
        if (mon_en && ((oQ !== prev_q) || (oRise !== '0) || (oFall !== '0))) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got q=%b rise=%b fall=%b", cyc, oQ, oRise, oFall);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || oQ !== e.q || oRise !== e.rise || oFall !== e.fall) begin
                    errors++;
                    $display("FAIL event got cyc=%0d q=%b rise=%b fall=%b exp cyc=%0d q=%b rise=%b fall=%b",
                             cyc, oQ, oRise, oFall, e.cyc, e.q, e.rise, e.fall);
                end
            end
        end
        prev_q = oQ;
    end

    // Edge on which oQ loads: STABLE ticked samples after the synchroniser has caught up.
    function automatic int exp_edge(input int c, input int div);
        int n = 0;
        for (int e = c + SYNC + 1; e < c + 10000; e++) begin
            if (div <= 1 || ((e - 1) % div) == 0) n++;
            if (n == STABLE) return e;
        end
        return -1;
    endfunction

    logic [CH-1:0] qm = '0;

    task automatic check_val(input string name, input logic [CH-1:0] got, input logic [CH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, want);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_events=%0d next_cyc=%0d", name, exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic apply_vec(input vec_t v);
        int            c;
        int            e;
        logic [CH-1:0] changed;
        ev_t           ev;
        @(negedge iClk);
        tick_div = v.div;
        iD       = v.d;
        c        = cyc;
        changed  = v.d ^ qm;
        if (changed != '0) begin
            e = exp_edge(c, v.div);
            if (e - c <= v.hold) begin
                ev.cyc  = e;
                ev.q    = v.d;
                ev.rise = EDGE_EN ? (changed & v.d) : '0;
                ev.fall = EDGE_EN ? (changed & ~v.d) : '0;
                exp_q.push_back(ev);
                qm = v.d;
            end
        end
        repeat (v.hold) @(negedge iClk);
        #1;
        check_drained("vec_events");
        check_val("vec_q", oQ, v.exp_q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[9];
        vec_t v;
        int   c;
        ev_t  ev;

        vecs[0] = '{d: 4'b0001, div: 1, hold: 24, exp_q: 4'b0001};
        vecs[1] = '{d: 4'b0011, div: 1, hold: 10, exp_q: 4'b0001};
        vecs[2] = '{d: 4'b0001, div: 1, hold: 24, exp_q: 4'b0001};
        vecs[3] = '{d: 4'b0101, div: 1, hold: 24, exp_q: 4'b0101};
        vecs[4] = '{d: 4'b0001, div: 4, hold: 80, exp_q: 4'b0001};
        vecs[5] = '{d: 4'b0000, div: 1, hold: 24, exp_q: 4'b0000};
        vecs[6] = '{d: 4'b1111, div: 1, hold: 24, exp_q: 4'b1111};
        vecs[7] = '{d: 4'b1010, div: 2, hold: 50, exp_q: 4'b1010};
        vecs[8] = '{d: 4'b0000, div: 1, hold: 24, exp_q: 4'b0000};

        #1;
        check_val("reset_q", oQ, '0);
        check_val("reset_rise", oRise, '0);
        check_val("reset_fall", oFall, '0);
        repeat (3) @(negedge iClk);
        iRst_n = 1'b1;
        prev_q = oQ;
        mon_en = 1'b1;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Reset in the middle of a count on channel 3 while other channels are high.
        v = '{d: 4'b0111, div: 1, hold: 24, exp_q: 4'b0111};
        apply_vec(v);
        @(negedge iClk);
        iD = 4'b1111;
        repeat (11) @(negedge iClk);
        #1;
        mon_en = 1'b0;
        iRst_n = 1'b0;
        #1;
        check_val("async_rst_q", oQ, '0);
        check_val("async_rst_rise", oRise, '0);
        check_val("async_rst_fall", oFall, '0);
        repeat (2) @(negedge iClk);
        check_val("rst_hold_q", oQ, '0);
        check_val("rst_hold_pulses", oRise | oFall, '0);
        iRst_n = 1'b1;
        c      = cyc;
        qm     = 4'b1111;
        ev.cyc  = c + SYNC + STABLE;
        ev.q    = 4'b1111;
        ev.rise = EDGE_EN ? 4'b1111 : 4'b0000;
        ev.fall = 4'b0000;
        exp_q.push_back(ev);
        prev_q = '0;
        mon_en = 1'b1;
        repeat (24) @(negedge iClk);
        #1;
        check_drained("post_reset_rise");
        check_val("post_reset_q", oQ, 4'b1111);

        // STABLE_CYCLES=1, SYNC_STAGES=3: oQ follows on the 4th edge after the change.
        @(negedge iClk);
        d1 = 1'b1;
        repeat (3) @(negedge iClk);
        check_val("s1_rise_before", {3'b000, q1}, 4'b0000);
        @(negedge iClk);
        check_val("s1_rise_q", {3'b000, q1}, 4'b0001);
        check_val("s1_rise_pulse", {3'b000, r1}, {3'b000, EDGE_EN});
        @(negedge iClk);
        check_val("s1_rise_width", {3'b000, r1}, 4'b0000);
        d1 = 1'b0;
        repeat (3) @(negedge iClk);
        check_val("s1_fall_before", {3'b000, q1}, 4'b0001);
        @(negedge iClk);
        check_val("s1_fall_q", {3'b000, q1}, 4'b0000);
        check_val("s1_fall_pulse", {3'b000, f1}, {3'b000, EDGE_EN});
        @(negedge iClk);
        check_val("s1_fall_width", {3'b000, f1}, 4'b0000);

        repeat (2) @(negedge iClk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter: CHANNELS, default 4, number of independent input channels; legal range 1..32.
REQ-002 Parameter: STABLE_CYCLES, default 16, consecutive ticked mismatch samples required to accept a new level; legal range 1..65535.
REQ-003 Parameter: SYNC_STAGES, default 2, synchroniser flop depth per channel; legal range 2..4.
REQ-004 Port: iClk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: iRst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port: iTick  input  1  sample-enable strobe; counters advance only when high. Tie high for per-clock sampling.
REQ-007 Port: iD  input  CHANNELS  raw asynchronous inputs (switches, buttons).
REQ-008 Port: oQ  output  CHANNELS  registered debounced level per channel.
REQ-009 Port: oRise  output  CHANNELS  one-cycle pulse per channel when oQ goes 0->1.
REQ-010 Port: oFall  output  CHANNELS  one-cycle pulse per channel when oQ goes 1->0.

Function
REQ-011 Each channel SHALL pass iD through SYNC_STAGES flops; the last stage is the channel sample S. Synchroniser flops are never gated by iTick.
REQ-012 Each channel SHALL hold a counter of width clog2(STABLE_CYCLES+1) bits.
REQ-013 If S equals oQ on any cycle, ticked or not, the counter SHALL clear to 0.
REQ-014 If S differs from oQ and iTick=1 and counter < STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 If S differs from oQ and iTick=0, the counter SHALL hold.
REQ-016 If S differs from oQ, iTick=1, and counter = STABLE_CYCLES-1, then on that edge oQ SHALL load S and the counter SHALL clear.
REQ-017 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-018 With iTick held high and iD steady after a change, oQ SHALL change on the (SYNC_STAGES+STABLE_CYCLES)-th rising edge after the change, counting the first sampling edge as 1. Default: 18 edges.
REQ-019 A mismatch lasting fewer than STABLE_CYCLES ticked samples, followed by a match, SHALL leave oQ unchanged and produce no pulse.
REQ-020 oRise and oFall SHALL be registered and assert on the same edge oQ updates, for exactly one clock cycle regardless of iTick.
REQ-021 oRise and oFall of the same channel SHALL never assert together.
REQ-022 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each resolve per REQ-013 to REQ-020.
REQ-023 With STABLE_CYCLES=1, oQ SHALL follow S on the first ticked cycle with S != oQ.

Reset
REQ-024 When iRst_n=0, all synchroniser flops, counters, oQ, oRise and oFall SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-025 Reset asserted mid-count SHALL discard the partial count and SHALL emit no pulse.
REQ-026 After reset release, an input already high SHALL be treated as a 0->1 transition: oQ rises and oRise pulses per REQ-018.

Configuration
REQ-027 Macro DEBOUNCE_BANK_EDGE_EN SHALL control the edge-pulse feature.
REQ-028 With DEBOUNCE_BANK_EDGE_EN defined, the oRise and oFall logic SHALL be built per REQ-020 and REQ-021.
REQ-029 Without the macro, oRise and oFall SHALL remain as ports, tied constant 0, with no edge registers built. oQ behaviour SHALL be identical in both builds.

Verification
REQ-030 Defaults, iTick=1, iD[0] steps 0->1 and holds -> oQ[0]=1 and oRise[0]=1 for one cycle at edge 18; all other channels remain 0.
REQ-031 Defaults, iD[1] high for 10 cycles then low -> oQ[1] stays 0, no oRise[1], counter[1] returns to 0.
REQ-032 Defaults, iTick=1 every 4th cycle, iD[2] 1->0 with oQ[2]=1 -> oQ[2] falls after 16 ticked mismatch samples; oFall[2] is exactly one clock wide.
REQ-033 iD[3] high, reset asserted when counter[3]=9 -> all outputs read 0 immediately. After release, oQ[3] rises 18 edges later.
REQ-034 iD=4'b1111 toggled together and held -> all four oQ bits and oRise bits assert on the same edge.
REQ-035 Build without DEBOUNCE_BANK_EDGE_EN, repeat REQ-030 -> oQ timing identical; oRise and oFall stay 0 throughout.
